// File: rtl/lvds_echo_responder.sv
// Echo-board partner of the LVDS link: loops every valid received word back to
// the transmitter through a small show-ahead FIFO, gated by link alignment.
module lvds_echo_responder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 2,
    parameter logic [31:0] FILL_WORD = 32'h52525252
) (
    input  logic        tx_inclock,
    input  logic        reset_n,
    input  logic        rx_align_done,
    input  logic        tx_align_done,
    input  logic [31:0] rx_word,
    input  logic        EN_rx_word,
    output logic        RDY_rx_word,
    output logic [31:0] tx_word,
    output logic        RDY_tx_word,
    input  logic        EN_tx_word,
    output logic        link_up,
    output logic [15:0] echo_count,
    output logic [7:0]  drop_count,
    output logic [7:0]  led_out
);

    // state     | meaning
    // WAIT_LINK | link not aligned; all traffic refused
    // RUN       | both directions aligned; echo traffic flows
    // FLUSH     | one cycle: discard queued words and count them as drops
    typedef enum logic [1:0] {
        WAIT_LINK = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2
    } state_t;

    localparam int unsigned SW = AW + 10;
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [15:0]   echo_count_q, echo_count_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic [7:0]    led_out_q, led_out_d;

    logic          run;
    logic          empty;
    logic          full;
    logic          aligned;
    logic          valid_in;
    logic          enq;
    logic          deq;
    logic          drop_ev;
    logic [AW:0]   occupancy;
    logic [SW-1:0] drop_sum;

    assign run       = (state_q == RUN);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign aligned   = rx_align_done && tx_align_done;
    assign valid_in  = EN_rx_word && rx_word[31];

    assign RDY_rx_word = run && !full;
    assign RDY_tx_word = run && !empty;
    assign link_up     = run;
    assign tx_word     = RDY_tx_word ? mem_q[rd_ptr_q[AW-1:0]] : FILL_WORD;
    assign echo_count  = echo_count_q;
    assign drop_count  = drop_count_q;
    assign led_out     = led_out_q;

    // Outside RUN, RDY_rx_word is low, so every valid word there is a drop.
    assign enq     = valid_in && RDY_rx_word;
    assign deq     = EN_tx_word && RDY_tx_word;
    assign drop_ev = valid_in && !RDY_rx_word;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_d        = mem_q;
        echo_count_d = echo_count_q;
        led_out_d    = led_out_q;
        drop_sum     = SW'(drop_count_q) + SW'(drop_ev);

        case (state_q)
            WAIT_LINK: begin
                if (aligned) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!aligned) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                rd_ptr_d = wr_ptr_q;
                drop_sum = drop_sum + SW'(occupancy);
                state_d  = WAIT_LINK;
            end
            default: begin
                state_d = WAIT_LINK;
            end
        endcase

        if (enq) begin
            mem_d[wr_ptr_q[AW-1:0]] = rx_word;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end

        if (deq) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            echo_count_d = echo_count_q + 16'd1;
            led_out_d    = tx_word[7:0];
        end

        drop_count_d = (drop_sum > SW'(8'hFF)) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge tx_inclock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= WAIT_LINK;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            echo_count_q <= '0;
            drop_count_q <= '0;
            led_out_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            echo_count_q <= echo_count_d;
            drop_count_q <= drop_count_d;
            led_out_q    <= led_out_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_lvds_echo_responder.sv
// Bench for lvds_echo_responder: directed link scenarios plus random traffic,
// checked against a queue-based reference model and an echo scoreboard.
module tb_lvds_echo_responder;

    localparam int          DEPTH = 4;
    localparam logic [31:0] FILL  = 32'h52525252;
    localparam int          M_WAIT  = 0;
    localparam int          M_RUN   = 1;
    localparam int          M_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxa = 1'b0;
    logic        txa = 1'b0;
    logic        en_rx = 1'b0;
    logic        en_tx = 1'b0;
    logic [31:0] rx = '0;
    logic        rdy_rx;
    logic        rdy_tx;
    logic [31:0] tx_word;
    logic        link_up;
    logic [15:0] echo_count;
    logic [7:0]  drop_count;
    logic [7:0]  led_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lvds_echo_responder dut (
        .tx_inclock    (clk),
        .reset_n       (rst_n),
        .rx_align_done (rxa),
        .tx_align_done (txa),
        .rx_word       (rx),
        .EN_rx_word    (en_rx),
        .RDY_rx_word   (rdy_rx),
        .tx_word       (tx_word),
        .RDY_tx_word   (rdy_tx),
        .EN_tx_word    (en_tx),
        .link_up       (link_up),
        .echo_count    (echo_count),
        .drop_count    (drop_count),
        .led_out       (led_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: link mode, FIFO contents as a queue, counters as integers.
    int          m_mode;
    logic [31:0] m_fifo[$];
    logic [31:0] sb_q[$];
    logic [15:0] m_echo;
    int          m_drop;
    logic [7:0]  m_led;

    function automatic void add_drop(input int n);
        m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic        aligned;
        logic        valid;
        int          n;
        logic [31:0] w;
        if (!rst_n) begin
            m_mode = M_WAIT;
            m_fifo.delete();
            sb_q.delete();
            m_echo = '0;
            m_drop = 0;
            m_led  = '0;
        end else begin
            aligned = rxa && txa;
            valid   = en_rx && rx[31];
            n       = m_fifo.size();
            case (m_mode)
                M_WAIT: begin
                    if (valid) add_drop(1);
                    if (aligned) m_mode = M_RUN;
                end
                M_RUN: begin
                    if (en_tx && n > 0) begin
                        w = m_fifo.pop_front();
                        m_echo = m_echo + 16'd1;
                        m_led  = w[7:0];
                    end
                    if (valid) begin
                        if (n < DEPTH) begin
                            m_fifo.push_back(rx);
                            sb_q.push_back(rx);
                        end else begin
                            add_drop(1);
                        end
                    end
                    if (!aligned) m_mode = M_FLUSH;
                end
                default: begin
                    add_drop(n + (valid ? 1 : 0));
                    m_fifo.delete();
                    sb_q.delete();
                    m_mode = M_WAIT;
                end
            endcase
        end
    end

    // Monitor: compares DUT status against the model and pops the scoreboard on each echo.
    always @(negedge clk) begin
        logic        exp_run;
        logic        has_word;
        logic [31:0] exp_word;
        exp_run  = (m_mode == M_RUN);
        has_word = exp_run && (m_fifo.size() > 0);
        chk("link_up", {31'd0, link_up}, {31'd0, exp_run});
        chk("rdy_rx", {31'd0, rdy_rx}, {31'd0, exp_run && (m_fifo.size() < DEPTH)});
        chk("rdy_tx", {31'd0, rdy_tx}, {31'd0, has_word});
        chk("tx_word", tx_word, has_word ? m_fifo[0] : FILL);
        chk("echo_count", {16'd0, echo_count}, {16'd0, m_echo});
        chk("drop_count", {24'd0, drop_count}, 32'(m_drop));
        chk("led_out", {24'd0, led_out}, {24'd0, m_led});
        if (rdy_tx && en_tx) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL echo_word: got %h expected none (scoreboard empty)", tx_word);
            end else begin
                exp_word = sb_q.pop_front();
                chk("echo_word", tx_word, exp_word);
            end
        end
    end

    initial begin
        int iters;
        logic link_ok;

        // Reset held while inputs are busy
        rst_n = 1'b0; en_rx = 1'b1; rx = 32'h80000001; en_tx = 1'b1; rxa = 1'b1; txa = 1'b1;
        repeat (3) tick();
        chk("rst_rdy_rx", {31'd0, rdy_rx}, 32'd0);
        chk("rst_rdy_tx", {31'd0, rdy_tx}, 32'd0);
        chk("rst_link_up", {31'd0, link_up}, 32'd0);
        chk("rst_tx_word", tx_word, 32'h52525252);
        chk("rst_echo", {16'd0, echo_count}, 32'd0);
        chk("rst_drop", {24'd0, drop_count}, 32'd0);
        chk("rst_led", {24'd0, led_out}, 32'd0);
        en_rx = 1'b0; en_tx = 1'b0; rst_n = 1'b1;
        tick();
        chk("run_entry", {31'd0, link_up}, 32'd1);

        // Two echoes
        en_rx = 1'b1; rx = 32'h80000001;
        chk("rdy_tx_before", {31'd0, rdy_tx}, 32'd0);
        tick();
        chk("rdy_tx_rise", {31'd0, rdy_tx}, 32'd1);
        chk("tx_first", tx_word, 32'h80000001);
        rx = 32'h8000ABCD;
        tick();
        en_rx = 1'b0; en_tx = 1'b1;
        tick();
        chk("tx_second", tx_word, 32'h8000ABCD);
        tick();
        en_tx = 1'b0;
        chk("echo_two", {16'd0, echo_count}, 32'd2);
        chk("led_cd", {24'd0, led_out}, 32'hCD);
        chk("empty_after", {31'd0, rdy_tx}, 32'd0);

        // Filler word
        en_rx = 1'b1; rx = 32'h12345678;
        tick();
        en_rx = 1'b0;
        tick();
        chk("filler_drop", {24'd0, drop_count}, 32'd0);
        chk("filler_rdy_tx", {31'd0, rdy_tx}, 32'd0);

        // Fill, overflow, then simultaneous enqueue and dequeue when full
        en_rx = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx = 32'h80000010 + 32'(i);
            tick();
        end
        chk("full_rdy_rx", {31'd0, rdy_rx}, 32'd0);
        rx = 32'h80000099;
        tick();
        chk("overflow_drop", {24'd0, drop_count}, 32'd1);
        rx = 32'h800000AA; en_tx = 1'b1;
        tick();
        en_rx = 1'b0; en_tx = 1'b0;
        chk("full_simul_drop", {24'd0, drop_count}, 32'd2);
        chk("full_simul_echo", {16'd0, echo_count}, 32'd3);
        chk("full_simul_head", tx_word, 32'h80000011);

        // Alignment loss with 3 queued words
        rxa = 1'b0;
        tick();
        chk("flush_link_up", {31'd0, link_up}, 32'd0);
        tick();
        chk("flush_drop", {24'd0, drop_count}, 32'd5);
        chk("flush_tx_word", tx_word, 32'h52525252);
        chk("flush_rdy_tx", {31'd0, rdy_tx}, 32'd0);
        rxa = 1'b1;
        tick();
        chk("realign_link_up", {31'd0, link_up}, 32'd1);
        chk("realign_empty", {31'd0, rdy_tx}, 32'd0);

        // Random traffic with link drops and one mid-run reset
        link_ok = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) link_ok = !link_ok;
            rxa   = link_ok;
            txa   = link_ok && ($urandom_range(0, 49) != 0);
            en_rx = ($urandom_range(0, 2) != 0);
            rx    = $urandom;
            rx[31] = ($urandom_range(0, 3) != 0);
            en_tx = $urandom_range(0, 1) != 0;
            if (i == 1500) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        // Saturating drop counter
        en_rx = 1'b0; en_tx = 1'b0; rxa = 1'b0; txa = 1'b0;
        repeat (3) tick();
        en_rx = 1'b1;
        for (int i = 0; i < 260; i++) begin
            rx = 32'h80000000 | 32'(i);
            tick();
        end
        en_rx = 1'b0;
        tick();
        chk("drop_saturate", {24'd0, drop_count}, 32'hFF);

        // Stream to echo_count = FFFF, then wrap
        rxa = 1'b1; txa = 1'b1;
        tick();
        en_rx = 1'b1; en_tx = 1'b1;
        iters = 0;
        while (m_echo != 16'hFFFF && iters < 70000) begin
            rx = $urandom;
            rx[31] = 1'b1;
            tick();
            iters++;
        end
        if (m_echo != 16'hFFFF) begin
            checks++;
            failures++;
            $display("FAIL stream_budget: got echo %h expected ffff within budget", m_echo);
        end
        en_tx = 1'b0;
        chk("echo_ffff", {16'd0, echo_count}, 32'h0000FFFF);
        tick();
        en_rx = 1'b0; en_tx = 1'b1;
        tick();
        en_tx = 1'b0;
        chk("echo_wrap", {16'd0, echo_count}, 32'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
